// File: rtl/trace_pkg.sv
// Shared definitions for the RAM trace packetizer.
//   - Packet tag bytes placed in the top byte of write/read/marker packets.
//   - evt_kind encodings as seen on the event bus (kind 3 is reserved).
//   - Serializer state encoding.
package trace_pkg;

    localparam logic [7:0] TAG_WRITE = 8'hAA;
    localparam logic [7:0] TAG_READ  = 8'hBB;
    localparam logic [7:0] TAG_MARK  = 8'hCC;

    localparam logic [1:0] EVT_ADDR  = 2'd0;
    localparam logic [1:0] EVT_WRITE = 2'd1;
    localparam logic [1:0] EVT_READ  = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/ram_trace_packetizer_if.sv
// Bus bundle between the event source, the packetizer and the USB FIFO pins.
//   evt_valid/evt_kind/evt_addr/evt_data : one-cycle RAM bus event strobe + payload
//   usb_full                             : positive-logic USB FIFO full flag
//   usb_d/usb_wr_strobe                  : byte stream towards the USB FIFO
//   usb_pktend_strobe                    : one-cycle flush request
// master = event source / USB FIFO model, slave = packetizer.
interface ram_trace_packetizer_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16
);
    logic              evt_valid;
    logic [1:0]        evt_kind;
    logic [ADDR_W-1:0] evt_addr;
    logic [DATA_W-1:0] evt_data;
    logic              usb_full;
    logic [7:0]        usb_d;
    logic              usb_wr_strobe;
    logic              usb_pktend_strobe;

    modport master (
        output evt_valid, evt_kind, evt_addr, evt_data, usb_full,
        input  usb_d, usb_wr_strobe, usb_pktend_strobe
    );

    modport slave (
        input  evt_valid, evt_kind, evt_addr, evt_data, usb_full,
        output usb_d, usb_wr_strobe, usb_pktend_strobe
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flop storage and a registered occupancy count.
//   clk/reset : clock, synchronous active-high reset
//   wr_en/wr_data : push; accepted when not full, or when full and popping
//   rd_en/rd_data : pop; rd_data always shows the head entry
//   full/empty/level : occupancy status
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_wr_s, do_rd_s;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and level; a pop frees the slot a full push needs.
    always_comb begin
        mem_d    = mem_q;
        do_rd_s  = rd_en && !empty;
        do_wr_s  = wr_en && (!full || do_rd_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_wr_s) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_rd_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_wr_s, do_rd_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end
endmodule

// File: rtl/ram_trace_packetizer.sv
// Packs synchronised RAM bus events into fixed-size packets, queues them and
// streams them MSB-first onto the byte-wide USB FIFO. Lost events are counted
// and reported by an in-band marker packet; idle partial USB packets are
// flushed with a PKTEND strobe.
//   mclk/reset  : clock, synchronous active-high reset
//   capture_en  : gates all capture; read_en : also capture read-data events
//   bus         : event inputs and USB FIFO signals (slave side)
//   fifo_level  : queued packets; overflow : pulse per dropped event
//   busy        : serializer is not idle
module ram_trace_packetizer
    import trace_pkg::*;
#(
    parameter int ADDR_W       = 23,
    parameter int DATA_W       = 16,
    parameter int PKT_BYTES    = 3,
    parameter int FIFO_DEPTH   = 16,
    parameter int FLUSH_CYCLES = 1024,
    parameter int CNT_W        = 16
) (
    input  logic                          mclk,
    input  logic                          reset,
    input  logic                          capture_en,
    input  logic                          read_en,
    ram_trace_packetizer_if.slave         bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          busy
);
    localparam int P     = PKT_BYTES * 8;
    localparam int PL_W  = P - 8;
    localparam int BC_W  = $clog2(PKT_BYTES + 1);
    localparam int TMR_W = $clog2(FLUSH_CYCLES + 1);

    ser_state_t       state_q, state_d;
    logic [P-1:0]     shift_q, shift_d;
    logic [BC_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]       usb_d_q, usb_d_d;
    logic             wr_q, wr_d;
    logic             pktend_q, pktend_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] drop_count_q, drop_count_d;
    logic             dirty_q, dirty_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    logic             accept_s, push_s, pop_s, drop_s, can_push_s;
    logic             fifo_full_s, fifo_empty_s;
    logic [P-1:0]     evt_pkt_s, push_data_s, fifo_rd_data_s;

    sync_fifo #(.WIDTH(P), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (mclk),
        .reset   (reset),
        .wr_en   (push_s),
        .wr_data (push_data_s),
        .rd_en   (pop_s),
        .rd_data (fifo_rd_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (fifo_level)
    );

    assign bus.usb_d             = usb_d_q;
    assign bus.usb_wr_strobe     = wr_q;
    assign bus.usb_pktend_strobe = pktend_q;
    assign overflow              = overflow_q;
    assign busy                  = busy_q;

    // Event qualification and packet encoding.
    always_comb begin
        accept_s  = 1'b0;
        evt_pkt_s = '0;
        case (bus.evt_kind)
            EVT_ADDR:  evt_pkt_s = P'(bus.evt_addr[ADDR_W-1:0]);
            EVT_WRITE: evt_pkt_s = {TAG_WRITE, PL_W'(bus.evt_data[DATA_W-1:0])};
            EVT_READ:  evt_pkt_s = {TAG_READ,  PL_W'(bus.evt_data[DATA_W-1:0])};
            default:   evt_pkt_s = '0;
        endcase
        if (bus.evt_valid && capture_en) begin
            case (bus.evt_kind)
                EVT_ADDR, EVT_WRITE: accept_s = 1'b1;
                EVT_READ:            accept_s = read_en;
                default:             accept_s = 1'b0;
            endcase
        end else begin
            accept_s = 1'b0;
        end
    end

    // Enqueue arbitration: a pending marker always wins the slot so it lands
    // ahead of any later data; an event colliding with it is itself counted lost.
    always_comb begin
        push_s       = 1'b0;
        push_data_s  = evt_pkt_s;
        drop_s       = 1'b0;
        drop_count_d = drop_count_q;
        can_push_s   = !fifo_full_s || pop_s;
        if ((drop_count_q != '0) && can_push_s) begin
            push_s      = 1'b1;
            push_data_s = {TAG_MARK, PL_W'(drop_count_q)};
            if (accept_s) begin
                drop_s       = 1'b1;
                drop_count_d = CNT_W'(1);
            end else begin
                drop_count_d = '0;
            end
        end else if (accept_s) begin
            if (can_push_s) begin
                push_s = 1'b1;
            end else begin
                drop_s = 1'b1;
                if (drop_count_q != '1) begin
                    drop_count_d = drop_count_q + CNT_W'(1);
                end else begin
                    drop_count_d = drop_count_q;
                end
            end
        end else begin
            push_s = 1'b0;
        end
        overflow_d = drop_s;
    end

    // Serializer next-state: load a packet in IDLE, emit one byte per non-full cycle in SEND.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        usb_d_d    = usb_d_q;
        wr_d       = 1'b0;
        pop_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    shift_d    = fifo_rd_data_s;
                    byte_cnt_d = BC_W'(PKT_BYTES);
                    state_d    = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (!bus.usb_full) begin
                    usb_d_d    = shift_q[P-1 -: 8];
                    wr_d       = 1'b1;
                    shift_d    = {shift_q[P-9:0], 8'h00};
                    byte_cnt_d = byte_cnt_q - BC_W'(1);
                    if (byte_cnt_q == BC_W'(1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_SEND;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Flush timer. It fires on the FLUSH_CYCLES-th idle cycle so the registered
    // PKTEND lands exactly FLUSH_CYCLES cycles after the last byte strobe.
    always_comb begin
        dirty_d  = dirty_q;
        timer_d  = timer_q;
        pktend_d = 1'b0;
        if (wr_d) begin
            dirty_d = 1'b1;
            timer_d = '0;
        end else if ((state_q == ST_IDLE) && fifo_empty_s && dirty_q) begin
            if (timer_q == TMR_W'(FLUSH_CYCLES - 1)) begin
                if (!bus.usb_full) begin
                    pktend_d = 1'b1;
                    dirty_d  = 1'b0;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q;
                end
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end
        end else begin
            timer_d = '0;
        end
    end

    // Control and output registers.
    always_ff @(posedge mclk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            usb_d_q      <= 8'h00;
            wr_q         <= 1'b0;
            pktend_q     <= 1'b0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
            drop_count_q <= '0;
            dirty_q      <= 1'b0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            byte_cnt_q   <= byte_cnt_d;
            usb_d_q      <= usb_d_d;
            wr_q         <= wr_d;
            pktend_q     <= pktend_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
            drop_count_q <= drop_count_d;
            dirty_q      <= dirty_d;
            timer_q      <= timer_d;
        end
    end
endmodule

// File: tb/tb_ram_trace_packetizer.sv
// Directed bench for ram_trace_packetizer with a byte scoreboard.
module tb_ram_trace_packetizer;
    import trace_pkg::*;

    logic       mclk;
    logic       reset;
    logic       capture_en;
    logic       read_en;
    logic [2:0] fifo_level;
    logic       overflow;
    logic       busy;

    ram_trace_packetizer_if #(.ADDR_W(23), .DATA_W(16)) bus ();

    ram_trace_packetizer #(
        .ADDR_W(23), .DATA_W(16), .PKT_BYTES(3),
        .FIFO_DEPTH(4), .FLUSH_CYCLES(8), .CNT_W(16)
    ) dut (
        .mclk       (mclk),
        .reset      (reset),
        .capture_en (capture_en),
        .read_en    (read_en),
        .bus        (bus.slave),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .busy       (busy)
    );

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         ov_cnt = 0;
    int         last_wr_cyc = 0;
    logic       hold_chk = 1'b0;
    logic [7:0] prev_d = 8'h00;
    logic [7:0] exp_q [$];
    int         wr_cyc_q [$];
    int         pk_cyc_q [$];

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input logic [23:0] p);
        exp_q.push_back(p[23:16]);
        exp_q.push_back(p[15:8]);
        exp_q.push_back(p[7:0]);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge mclk);
    endtask

    // Called just after a negedge; the event is sampled at the next posedge.
    task automatic send_evt(input logic [1:0] k, input logic [22:0] a, input logic [15:0] d);
        bus.evt_valid = 1'b1;
        bus.evt_kind  = k;
        bus.evt_addr  = a;
        bus.evt_data  = d;
        @(negedge mclk);
        bus.evt_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy || fifo_level != 3'd0) && n < 300) begin
            @(negedge mclk);
            n++;
        end
        check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Output monitor: scoreboard bytes, hold stability, pulse bookkeeping.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge mclk);
            cyc++;
            if (bus.usb_wr_strobe) begin
                wr_cyc_q.push_back(cyc);
                last_wr_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("extra_byte", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", 32'(bus.usb_d), 32'(e));
                end
            end else if (hold_chk) begin
                check("hold_stable", 32'(bus.usb_d), 32'(prev_d));
            end
            prev_d = bus.usb_d;
            if (bus.usb_pktend_strobe) pk_cyc_q.push_back(cyc);
            if (overflow) ov_cnt++;
        end
    end

    initial begin
        int  ov_base;
        int  wr_base;
        int  pk_base;
        int  diff;
        logic seen;

        reset         = 1'b1;
        capture_en    = 1'b1;
        read_en       = 1'b0;
        bus.evt_valid = 1'b0;
        bus.evt_kind  = 2'd0;
        bus.evt_addr  = 23'd0;
        bus.evt_data  = 16'd0;
        bus.usb_full  = 1'b0;
        tick(3);
        check("rst_wr",     32'(bus.usb_wr_strobe),     32'd0);
        check("rst_pktend", 32'(bus.usb_pktend_strobe), 32'd0);
        check("rst_usb_d",  32'(bus.usb_d),             32'd0);
        check("rst_level",  32'(fifo_level),            32'd0);
        check("rst_ovf",    32'(overflow),              32'd0);
        check("rst_busy",   32'(busy),                  32'd0);
        reset = 1'b0;
        tick(2);

        // Address then write, back to back, full throughput.
        wr_base = wr_cyc_q.size();
        push_pkt(24'h012345);
        push_pkt(24'hAABEEF);
        send_evt(EVT_ADDR, 23'h12345, 16'h0000);
        check("enq_latency", 32'(fifo_level), 32'd1);
        send_evt(EVT_WRITE, 23'h0, 16'hBEEF);
        wait_drain("t1");
        check("t1_strobes", 32'(wr_cyc_q.size() - wr_base), 32'd6);
        check("t1_byte_gap", 32'(wr_cyc_q[wr_base+1] - wr_cyc_q[wr_base]), 32'd1);
        check("t1_pkt_gap",  32'(wr_cyc_q[wr_base+3] - wr_cyc_q[wr_base]), 32'd4);
        tick(20);

        // Read gating, capture gating, reserved kind.
        ov_base = ov_cnt;
        send_evt(EVT_READ, 23'h0, 16'h5555);
        send_evt(2'd3, 23'h0, 16'h1111);
        capture_en = 1'b0;
        send_evt(EVT_WRITE, 23'h0, 16'h2222);
        capture_en = 1'b1;
        tick(3);
        check("ignored_level", 32'(fifo_level), 32'd0);
        check("ignored_busy",  32'(busy),       32'd0);
        check("ignored_ovf",   32'(ov_cnt - ov_base), 32'd0);
        read_en = 1'b1;
        push_pkt(24'hBB5555);
        send_evt(EVT_READ, 23'h0, 16'h5555);
        wait_drain("read");
        tick(20);

        // usb_full toggling mid-packet.
        wr_base = wr_cyc_q.size();
        push_pkt(24'hAA1234);
        push_pkt(24'hAA5678);
        send_evt(EVT_WRITE, 23'h0, 16'h1234);
        send_evt(EVT_WRITE, 23'h0, 16'h5678);
        hold_chk = 1'b1;
        repeat (16) begin
            bus.usb_full = ~bus.usb_full;
            tick(1);
        end
        bus.usb_full = 1'b0;
        wait_drain("toggle");
        hold_chk = 1'b0;
        check("toggle_strobes", 32'(wr_cyc_q.size() - wr_base), 32'd6);
        tick(20);

        // Overflow: one packet parked in the serializer, then 7 writes into a depth-4 FIFO.
        bus.usb_full = 1'b1;
        push_pkt(24'h2A5A5A);
        send_evt(EVT_ADDR, 23'h2A5A5A, 16'h0000);
        tick(3);
        check("park_busy",  32'(busy),       32'd1);
        check("park_level", 32'(fifo_level), 32'd0);
        ov_base = ov_cnt;
        for (int i = 0; i < 7; i++) begin
            send_evt(EVT_WRITE, 23'h0, 16'(16'h1000 + i));
        end
        for (int i = 0; i < 4; i++) begin
            push_pkt({8'hAA, 16'(16'h1000 + i)});
        end
        tick(2);
        check("ovf_level", 32'(fifo_level), 32'd4);
        check("ovf_pulses", 32'(ov_cnt - ov_base), 32'd3);
        push_pkt(24'hCC0003);
        bus.usb_full = 1'b0;
        wait_drain("ovf");
        tick(20);

        // Event colliding with the marker enqueue.
        bus.usb_full = 1'b1;
        push_pkt(24'h000055);
        send_evt(EVT_ADDR, 23'h000055, 16'h0000);
        tick(3);
        ov_base = ov_cnt;
        for (int i = 0; i < 6; i++) begin
            send_evt(EVT_WRITE, 23'h0, 16'(16'h2000 + i));
        end
        for (int i = 0; i < 4; i++) begin
            push_pkt({8'hAA, 16'(16'h2000 + i)});
        end
        tick(2);
        check("coll_pre_ovf", 32'(ov_cnt - ov_base), 32'd2);
        push_pkt(24'hCC0002);
        push_pkt(24'hCC0001);
        bus.usb_full = 1'b0;
        tick(3);
        send_evt(EVT_WRITE, 23'h0, 16'h3333);
        tick(2);
        check("coll_ovf", 32'(ov_cnt - ov_base), 32'd3);
        wait_drain("coll");
        tick(20);

        // Flush after idle.
        pk_cyc_q.delete();
        push_pkt(24'h000001);
        send_evt(EVT_ADDR, 23'h000001, 16'h0000);
        wait_drain("flush");
        tick(30);
        check("flush_count", 32'(pk_cyc_q.size()), 32'd1);
        diff = (pk_cyc_q.size() > 0) ? (pk_cyc_q[0] - last_wr_cyc) : 0;
        check("flush_delay", 32'(diff), 32'd8);

        // Reset in the middle of a packet.
        push_pkt(24'h0ABCDE);
        push_pkt(24'hAA4321);
        send_evt(EVT_ADDR, 23'h0ABCDE, 16'h0000);
        send_evt(EVT_WRITE, 23'h0, 16'h4321);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge mclk);
            if (bus.usb_wr_strobe) seen = 1'b1;
        end
        check("rst_mid_started", 32'(seen), 32'd1);
        #1;
        reset = 1'b1;
        exp_q.delete();
        wr_base = wr_cyc_q.size();
        pk_base = pk_cyc_q.size();
        @(negedge mclk);
        check("rstmid_wr",    32'(bus.usb_wr_strobe), 32'd0);
        check("rstmid_level", 32'(fifo_level),        32'd0);
        check("rstmid_busy",  32'(busy),              32'd0);
        tick(2);
        reset = 1'b0;
        tick(20);
        check("rstmid_no_wr",     32'(wr_cyc_q.size() - wr_base), 32'd0);
        check("rstmid_no_pktend", 32'(pk_cyc_q.size() - pk_base), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
